// File: rtl/ysyx_24100029_bpu_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor.
package ysyx_24100029_bpu_pkg;

    typedef enum logic [1:0] {
        BrCond = 2'b00,
        BrJmp  = 2'b01,
        BrCall = 2'b10,
        BrRet  = 2'b11
    } br_type_e;

    // Tag field sized for the smallest table; unused upper bits stay zero.
    localparam int unsigned TAG_W = 30;
    localparam logic [1:0] CTR_WEAK_TAKEN = 2'b10;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        br_type_e         btype;
        logic [1:0]       ctr;
    } btb_entry_t;

    function automatic logic [1:0] sat_ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

    function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc, input int unsigned iw);
        return TAG_W'(pc >> (iw + 2));
    endfunction

endpackage

// File: rtl/ysyx_24100029_btb.sv
// Direct-mapped BTB: combinational lookup and update-read ports, one synchronous write port.
module ysyx_24100029_btb
    import ysyx_24100029_bpu_pkg::*;
#(
    parameter int unsigned ENTRIES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_lk_pc,
    output logic        o_lk_hit,
    output logic [31:0] o_lk_target,
    output br_type_e    o_lk_type,
    output logic [1:0]  o_lk_ctr,
    input  logic [31:0] i_up_pc,
    output logic        o_up_hit,
    output btb_entry_t  o_up_entry,
    input  logic        i_wr_en,
    input  btb_entry_t  i_wr_entry
);

    localparam int unsigned IW = $clog2(ENTRIES);

    btb_entry_t    r_mem [ENTRIES];
    logic [IW-1:0] w_lk_idx;
    logic [IW-1:0] w_up_idx;
    btb_entry_t    w_lk_entry;

    assign w_lk_idx   = i_lk_pc[IW+1:2];
    assign w_up_idx   = i_up_pc[IW+1:2];
    assign w_lk_entry = r_mem[w_lk_idx];

    assign o_lk_hit    = w_lk_entry.valid && (w_lk_entry.tag == pc_tag(i_lk_pc, IW));
    assign o_lk_target = w_lk_entry.target;
    assign o_lk_type   = w_lk_entry.btype;
    assign o_lk_ctr    = w_lk_entry.ctr;

    assign o_up_entry = r_mem[w_up_idx];
    assign o_up_hit   = o_up_entry.valid && (o_up_entry.tag == pc_tag(i_up_pc, IW));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem <= '{default: '0};
        end else if (i_wr_en) begin
            r_mem[w_up_idx] <= i_wr_entry;
        end
    end

endmodule

// File: rtl/ysyx_24100029_npc_gen.sv
// Fetch PC register, next-PC prediction mux, RAS push/pop strobes and BTB training.
module ysyx_24100029_npc_gen
    import ysyx_24100029_bpu_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = 16,
    parameter logic [31:0] RESET_PC    = 32'h3000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] fetch_pc,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    input  logic        flush_valid,
    input  logic [31:0] flush_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    input  logic [1:0]  upd_type,
    output logic        ras_w_en,
    output logic [31:0] ras_waddr,
    output logic        ras_r_en,
    input  logic [31:0] ras_raddr
);

    localparam int unsigned IW = $clog2(BTB_ENTRIES);

    logic [31:0] r_pc;
    logic        r_valid;
    logic        w_fire;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_npc;
    logic        w_lk_hit;
    logic [31:0] w_lk_target;
    br_type_e    w_lk_type;
    logic [1:0]  w_lk_ctr;
    logic        w_up_hit;
    btb_entry_t  w_up_entry;
    logic        w_wr_en;
    btb_entry_t  w_wr_entry;
    br_type_e    w_upd_type;

    ysyx_24100029_btb #(
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .i_clk       (clock),
        .i_rst_n     (reset),
        .i_lk_pc     (r_pc),
        .o_lk_hit    (w_lk_hit),
        .o_lk_target (w_lk_target),
        .o_lk_type   (w_lk_type),
        .o_lk_ctr    (w_lk_ctr),
        .i_up_pc     (upd_pc),
        .o_up_hit    (w_up_hit),
        .o_up_entry  (w_up_entry),
        .i_wr_en     (w_wr_en),
        .i_wr_entry  (w_wr_entry)
    );

    assign fetch_pc    = r_pc;
    assign fetch_valid = r_valid;
    assign w_fire      = r_valid & fetch_ready;
    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_upd_type  = br_type_e'(upd_type);

    always_comb begin
        w_npc = w_pc_plus4;
        if (w_lk_hit) begin
            unique case (w_lk_type)
                BrCond:        w_npc = w_lk_ctr[1] ? w_lk_target : w_pc_plus4;
                BrJmp, BrCall: w_npc = w_lk_target;
                BrRet:         w_npc = ras_raddr;
                default:       w_npc = w_pc_plus4;
            endcase
        end
    end

    // A flush squashes the fetched instruction, so it must not touch the RAS.
    assign ras_w_en  = w_fire & w_lk_hit & (w_lk_type == BrCall) & ~flush_valid;
    assign ras_r_en  = w_fire & w_lk_hit & (w_lk_type == BrRet) & ~flush_valid;
    assign ras_waddr = w_pc_plus4;

    always_comb begin
        w_wr_en    = 1'b0;
        w_wr_entry = w_up_entry;
        if (upd_valid) begin
            if (w_up_hit && w_upd_type == BrCond) begin
                w_wr_en        = 1'b1;
                w_wr_entry.ctr = sat_ctr_next(w_up_entry.ctr, upd_taken);
                if (upd_taken) begin
                    w_wr_entry.target = upd_target;
                end
            end else if (w_up_hit) begin
                w_wr_en           = 1'b1;
                w_wr_entry.target = upd_target;
                w_wr_entry.btype  = w_upd_type;
            end else if (upd_taken || w_upd_type != BrCond) begin
                w_wr_en    = 1'b1;
                w_wr_entry = '{valid:  1'b1,
                               tag:    pc_tag(upd_pc, IW),
                               target: upd_target,
                               btype:  w_upd_type,
                               ctr:    CTR_WEAK_TAKEN};
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc    <= RESET_PC;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b1;
            if (flush_valid) begin
                r_pc <= flush_pc;
            end else if (w_fire) begin
                r_pc <= w_npc;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24100029_npc_gen.sv
// Scoreboard bench for the next-PC generator: directed scenarios followed by random traffic.
module tb_ysyx_24100029_npc_gen;

    localparam int unsigned N      = 16;
    localparam logic [31:0] RST_PC = 32'h3000_0000;
    localparam logic [1:0]  T_BR   = 2'd0;
    localparam logic [1:0]  T_CALL = 2'd2;
    localparam logic [1:0]  T_RET  = 2'd3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic        fetch_ready = 1'b0;
    logic        flush_valid = 1'b0;
    logic [31:0] flush_pc = 32'd0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = 32'd0;
    logic [31:0] upd_target = 32'd0;
    logic        upd_taken = 1'b0;
    logic [1:0]  upd_type = 2'd0;
    logic        ras_w_en;
    logic [31:0] ras_waddr;
    logic        ras_r_en;
    logic [31:0] ras_raddr = 32'd0;

    int n_chk  = 0;
    int n_fail = 0;
    logic rst_lvl = 1'b0;

    ysyx_24100029_npc_gen dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_pc    (fetch_pc),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .flush_valid (flush_valid),
        .flush_pc    (flush_pc),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_target  (upd_target),
        .upd_taken   (upd_taken),
        .upd_type    (upd_type),
        .ras_w_en    (ras_w_en),
        .ras_waddr   (ras_waddr),
        .ras_r_en    (ras_r_en),
        .ras_raddr   (ras_raddr)
    );

    always #5 clock = ~clock;

    // Reference model: the BTB as plain per-slot records, the PC as a number.
    bit          m_v   [N];
    int unsigned m_tag [N];
    logic [31:0] m_tgt [N];
    int          m_typ [N];
    int          m_ctr [N];
    logic [31:0] m_pc;
    bit          m_fv;

    typedef struct {
        logic [31:0] pc;
        logic        v;
        logic        w;
        logic [31:0] wa;
        logic        r;
    } exp_t;
    exp_t sb[$];

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc / 4) % N;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc / (4 * N);
    endfunction

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_PC;
        m_fv = 1'b0;
        for (int i = 0; i < N; i++) m_v[i] = 1'b0;
    endtask

    task automatic model_update(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                                input logic [1:0] typ);
        int unsigned i;
        bit hit;
        int t;
        i   = idx_of(pc);
        t   = int'(typ);
        hit = m_v[i] && (m_tag[i] == tag_of(pc));
        if (hit && t == 0) begin
            if (tk) begin
                m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                m_tgt[i] = tgt;
            end else begin
                m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
            end
        end else if (hit) begin
            m_tgt[i] = tgt;
            m_typ[i] = t;
        end else if (tk || t != 0) begin
            m_v[i]   = 1'b1;
            m_tag[i] = tag_of(pc);
            m_tgt[i] = tgt;
            m_typ[i] = t;
            m_ctr[i] = 2;
        end
    endtask

    // One clock: drive at negedge, post the expected response, advance the model at posedge.
    task automatic step(input logic fl, input logic [31:0] flpc, input logic uv,
                        input logic [31:0] upc, input logic [31:0] utgt, input logic utk,
                        input logic [1:0] utyp, input logic rdy, input logic [31:0] raddr,
                        input logic chk, input logic [31:0] chkpc, input string nm);
        exp_t        e;
        logic [31:0] npc;
        bit          hit;
        bit          fire;
        int unsigned i;
        @(negedge clock);
        reset       = rst_lvl;
        flush_valid = fl;
        flush_pc    = flpc;
        upd_valid   = uv;
        upd_pc      = upc;
        upd_target  = utgt;
        upd_taken   = utk;
        upd_type    = utyp;
        fetch_ready = rdy;
        ras_raddr   = raddr;
        #1;
        if (!reset) model_reset();
        i   = idx_of(m_pc);
        hit = m_v[i] && (m_tag[i] == tag_of(m_pc));
        npc = m_pc + 32'd4;
        if (hit) begin
            if (m_typ[i] == 0 && m_ctr[i] >= 2) npc = m_tgt[i];
            else if (m_typ[i] == 1 || m_typ[i] == 2) npc = m_tgt[i];
            else if (m_typ[i] == 3) npc = raddr;
        end
        fire = m_fv && rdy;
        e.pc = m_pc;
        e.v  = m_fv;
        e.w  = fire && hit && m_typ[i] == 2 && !fl;
        e.wa = m_pc + 32'd4;
        e.r  = fire && hit && m_typ[i] == 3 && !fl;
        sb.push_back(e);
        if (chk) check32(nm, fetch_pc, chkpc);
        @(posedge clock);
        if (!reset) begin
            model_reset();
        end else begin
            if (uv) model_update(upc, utgt, utk, utyp);
            if (fl) m_pc = flpc;
            else if (fire) m_pc = npc;
            m_fv = 1'b1;
        end
    endtask

    task automatic idle(input logic rdy, input logic [31:0] raddr, input logic chk,
                        input logic [31:0] pc, input string nm);
        step(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, T_BR, rdy, raddr, chk, pc, nm);
    endtask

    task automatic flush_to(input logic [31:0] pc);
        step(1'b1, pc, 1'b0, 32'd0, 32'd0, 1'b0, T_BR, 1'b0, 32'd0, 1'b0, 32'd0, "flush");
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                       input logic [1:0] typ);
        step(1'b0, 32'd0, 1'b1, pc, tgt, tk, typ, 1'b0, 32'd0, 1'b0, 32'd0, "upd");
    endtask

    // Monitor: drains every expectation posted this cycle against the settled outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                check32("fetch_pc", fetch_pc, e.pc);
                check1("fetch_valid", fetch_valid, e.v);
                check1("ras_w_en", ras_w_en, e.w);
                check1("ras_r_en", ras_r_en, e.r);
                if (e.w) check32("ras_waddr", ras_waddr, e.wa);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic        fl, uv, utk, rdy;
        logic [31:0] flpc, upc, utgt, raddr;
        logic [1:0]  utyp;

        #2;
        reset = 1'b0;
        model_reset();

        // Reset, sequential fetch, stall
        idle(1'b1, 32'd0, 1'b1, RST_PC, "rst_pc");
        idle(1'b1, 32'd0, 1'b1, RST_PC, "rst_pc_hold");
        rst_lvl = 1'b1;
        idle(1'b1, 32'd0, 1'b1, RST_PC, "first_pc");
        idle(1'b1, 32'd0, 1'b1, RST_PC, "first_fire");
        idle(1'b1, 32'd0, 1'b1, 32'h3000_0004, "seq_4");
        idle(1'b1, 32'd0, 1'b1, 32'h3000_0008, "seq_8");
        for (int k = 0; k < 3; k++) idle(1'b0, 32'd0, 1'b1, 32'h3000_000C, "stall");

        // Conditional branch training and saturation
        upd(32'h3000_0010, 32'h3000_0100, 1'b1, T_BR);
        flush_to(32'h3000_0010);
        idle(1'b1, 32'd0, 1'b1, 32'h3000_0010, "br_at");
        idle(1'b0, 32'd0, 1'b1, 32'h3000_0100, "br_taken");
        upd(32'h3000_0010, 32'h3000_0100, 1'b0, T_BR);
        upd(32'h3000_0010, 32'h3000_0100, 1'b0, T_BR);
        flush_to(32'h3000_0010);
        idle(1'b1, 32'd0, 1'b1, 32'h3000_0010, "br_at2");
        idle(1'b0, 32'd0, 1'b1, 32'h3000_0014, "br_not_taken");
        for (int k = 0; k < 4; k++) upd(32'h3000_0010, 32'h3000_0100, 1'b1, T_BR);
        upd(32'h3000_0010, 32'h3000_0100, 1'b0, T_BR);
        flush_to(32'h3000_0010);
        idle(1'b1, 32'd0, 1'b1, 32'h3000_0010, "br_at3");
        idle(1'b0, 32'd0, 1'b1, 32'h3000_0100, "br_saturated");

        // Call then return
        upd(32'h3000_0020, 32'h3000_0200, 1'b1, T_CALL);
        upd(32'h3000_0204, 32'h3000_0300, 1'b1, T_RET);
        flush_to(32'h3000_0020);
        idle(1'b1, 32'h3000_0024, 1'b1, 32'h3000_0020, "call_at");
        idle(1'b1, 32'h3000_0024, 1'b1, 32'h3000_0200, "call_tgt");
        idle(1'b1, 32'h3000_0024, 1'b1, 32'h3000_0204, "ret_at");
        idle(1'b0, 32'h3000_0024, 1'b1, 32'h3000_0024, "ret_tgt");

        // Flush beats a fire on a trained call
        flush_to(32'h3000_0020);
        step(1'b1, 32'h3000_0400, 1'b0, 32'd0, 32'd0, 1'b0, T_BR, 1'b1, 32'h3000_0024,
             1'b1, 32'h3000_0020, "flush_prio_at");
        idle(1'b0, 32'd0, 1'b1, 32'h3000_0400, "flush_prio_pc");

        // Aliasing and same-cycle update
        flush_to(32'h3000_0050);
        idle(1'b1, 32'd0, 1'b1, 32'h3000_0050, "alias_at");
        idle(1'b0, 32'd0, 1'b1, 32'h3000_0054, "alias_miss");
        flush_to(32'h3000_0010);
        step(1'b0, 32'd0, 1'b1, 32'h3000_0010, 32'h3000_0100, 1'b0, T_BR, 1'b1, 32'd0,
             1'b1, 32'h3000_0010, "same_cyc_at");
        idle(1'b0, 32'd0, 1'b1, 32'h3000_0100, "same_cyc_old");
        flush_to(32'h3000_0010);
        idle(1'b1, 32'd0, 1'b1, 32'h3000_0010, "same_cyc_at2");
        idle(1'b0, 32'd0, 1'b1, 32'h3000_0014, "same_cyc_new");

        // Sequential fetch wraps at the top of the address space
        flush_to(32'hFFFF_FFFC);
        idle(1'b1, 32'd0, 1'b1, 32'hFFFF_FFFC, "wrap_at");
        idle(1'b0, 32'd0, 1'b1, 32'h0000_0000, "wrap_pc");

        // Reset asserted mid-run
        flush_to(32'h3000_0200);
        #1;
        fetch_ready = 1'b1;
        check32("mid_pre_pc", fetch_pc, 32'h3000_0200);
        #1;
        rst_lvl = 1'b0;
        reset   = 1'b0;
        model_reset();
        #1;
        check32("mid_rst_pc", fetch_pc, RST_PC);
        check1("mid_rst_valid", fetch_valid, 1'b0);
        check1("mid_rst_ras_w", ras_w_en, 1'b0);
        check1("mid_rst_ras_r", ras_r_en, 1'b0);
        idle(1'b1, 32'd0, 1'b1, RST_PC, "mid_rst_hold");
        rst_lvl = 1'b1;
        idle(1'b1, 32'd0, 1'b1, RST_PC, "post_rst_pc");
        idle(1'b1, 32'd0, 1'b1, RST_PC, "post_rst_fire");
        flush_to(32'h3000_0010);
        idle(1'b1, 32'd0, 1'b1, 32'h3000_0010, "post_rst_at");
        idle(1'b0, 32'd0, 1'b1, 32'h3000_0014, "post_rst_cleared");

        // Random traffic over a small address window so entries hit and alias often
        for (int k = 0; k < 600; k++) begin
            fl    = ($urandom_range(0, 9) == 0);
            flpc  = 32'h3000_0000 | (32'($urandom_range(0, 63)) << 2);
            uv    = ($urandom_range(0, 2) != 0);
            upc   = ($urandom_range(0, 1) == 0) ? m_pc
                                                : 32'h3000_0000 | (32'($urandom_range(0, 63)) << 2);
            utgt  = 32'h3000_0000 | (32'($urandom_range(0, 63)) << 2);
            utk   = 1'($urandom_range(0, 1));
            utyp  = 2'($urandom_range(0, 3));
            rdy   = ($urandom_range(0, 3) != 0);
            raddr = 32'h3000_0000 | (32'($urandom_range(0, 63)) << 2);
            step(fl, flpc, uv, upc, utgt, utk, utyp, rdy, raddr, 1'b0, 32'd0, "rand");
        end

        @(negedge clock);
        #3;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
